// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter family.
// The state enum is common to the left and right variants.
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } shift_state_t;

  localparam int SHIFT_N = 32;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a "count is one" flag.
// Saturates at zero so it can never wrap around.
module down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic         one
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority; decrement only while nonzero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = d;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign one = (count_q == W'(1));

endmodule

// File: rtl/shift_left_sequential.sv
// Multi-cycle left shifter, one bit per clock, valid/ready on both sides.
// SHIFT_LEFT_SEQUENTIAL_ROTATE_EN adds i_rotate for rotate-left.
module shift_left_sequential
  import shift_pkg::*;
#(
  parameter  int N = SHIFT_N,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] in,
  input  logic [S-1:0] shamt,
`ifdef SHIFT_LEFT_SEQUENTIAL_ROTATE_EN
  input  logic         i_rotate,
`endif
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  shift_state_t state_q;
  shift_state_t state_d;
  logic [N-1:0] data_q;
  logic [N-1:0] data_d;
  logic [N-1:0] step;
  logic         cnt_load;
  logic         cnt_en;
  logic         cnt_one;

`ifdef SHIFT_LEFT_SEQUENTIAL_ROTATE_EN
  logic rot_q;
  logic rot_d;

  // Rotate mode is latched with the operand at acceptance.
  always_comb begin
    rot_d = rot_q;
    if (state_q == S_IDLE && i_valid) begin
      rot_d = i_rotate;
    end
  end

  // Rotate mode register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_q <= 1'b0;
    end else begin
      rot_q <= rot_d;
    end
  end

  assign step = {data_q[N-2:0], rot_q & data_q[N-1]};
`else
  assign step = {data_q[N-2:0], 1'b0};
`endif

  down_counter #(
    .W(S)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .d    (shamt),
    .one  (cnt_one)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          data_d   = in;
          cnt_load = 1'b1;
          state_d  = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = step;
        cnt_en = 1'b1;
        if (cnt_one) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (o_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out     = data_q;
  assign i_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign busy    = (state_q == S_SHIFT) || (state_q == S_DONE);

endmodule
